// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core
// memory-access stage (port C) and the loader/debug port (port L).
// The core has priority; a saturating starvation counter force-grants a
// loader that has been denied STARVE_LIMIT cycles in a row. Load data comes
// back one cycle after issue and is steered to whichever port issued it.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rstd,
  // core port
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [1:0]  c_width,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        core_stall,
  // loader port
  input  logic        l_req,
  input  logic        l_we,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  input  logic [1:0]  l_width,
  output logic        l_gnt,
  output logic        l_rvalid,
  output logic [31:0] l_rdata,
  // memory side
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [1:0]  m_width,
  input  logic [31:0] m_rdata
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             rd_pend;
  logic             rd_owner;   // 0 = core, 1 = loader
  logic             force_gnt;

  // Grants depend only on requests and registered state, never on m_rdata.
  // Nothing is granted while reset is asserted, so a load presented during
  // reset can never produce a read-data pulse afterwards.
  assign force_gnt  = l_req & (starve_cnt == LIMIT);
  assign l_gnt      = ~rstd & l_req & (~c_req | force_gnt);
  assign c_gnt      = ~rstd & c_req & ~l_gnt;
  assign core_stall = c_req & ~c_gnt;
  assign m_en       = c_gnt | l_gnt;

  // Memory-side mux: steer the granted port, drive all zeros when idle.
  always_comb begin
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_width = '0;
    if (c_gnt) begin
      m_we    = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
      m_width = c_width;
    end else if (l_gnt) begin
      m_we    = l_we;
      m_addr  = l_addr;
      m_wdata = l_wdata;
      m_width = l_width;
    end
  end

  // Starvation counter and read-return tracking.
  always_ff @(posedge clk) begin
    if (rstd) begin
      starve_cnt <= '0;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      if (l_req & ~l_gnt)
        starve_cnt <= (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 1'b1;
      else
        starve_cnt <= '0;
      rd_pend <= m_en & ~m_we;
      if (m_en & ~m_we)
        rd_owner <= l_gnt;
    end
  end

  // Read data is only presented on the port that owns the returning load.
  assign c_rvalid = rd_pend & ~rd_owner;
  assign l_rvalid = rd_pend & rd_owner;
  assign c_rdata  = c_rvalid ? m_rdata : 32'h0;
  assign l_rdata  = l_rvalid ? m_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors for dmem_arbiter with a small
// one-cycle-latency word memory model on the memory side.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rstd;
  logic        c_req, c_we;
  logic [31:0] c_addr, c_wdata;
  logic [1:0]  c_width;
  logic        c_gnt, c_rvalid, core_stall;
  logic [31:0] c_rdata;
  logic        l_req, l_we;
  logic [31:0] l_addr, l_wdata;
  logic [1:0]  l_width;
  logic        l_gnt, l_rvalid;
  logic [31:0] l_rdata;
  logic        m_en, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [1:0]  m_width;
  logic [31:0] m_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .rstd(rstd),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_width(c_width), .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .core_stall(core_stall),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_width(l_width), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_width(m_width), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // word memory model, read data valid the cycle after a read issue
  logic [31:0] mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'hDEADBEEF;  // 0x100
    mem[8'h04] = 32'hA5A51010;  // 0x10
    mem[8'h08] = 32'h5A5A2020;  // 0x20
    mem[8'h01] = 32'h0BADF00D;  // 0x04
  end
  always @(posedge clk) begin
    if (m_en & m_we) mem[m_addr[9:2]] <= m_wdata;
    m_rdata <= (m_en & ~m_we) ? mem[m_addr[9:2]] : 32'h0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt();
    return 32'(dut.starve_cnt);
  endfunction

  initial begin
    rstd = 1'b1;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_width = 0;
    l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0; l_width = 0;
    tick; tick;
    // reset state
    chk("rst_m_en", 32'(m_en), 0);
    chk("rst_rvalid", 32'({c_rvalid, l_rvalid}), 0);
    chk("rst_cnt", cnt(), 0);
    chk("rst_gnt", 32'({c_gnt, l_gnt}), 0);

    // core only load
    rstd = 1'b0;
    c_req = 1; c_we = 0; c_addr = 32'h100; c_width = 2'd2;
    #1;
    chk("c1_gnt", 32'(c_gnt), 1);
    chk("c1_m_en", 32'(m_en), 1);
    chk("c1_m_addr", m_addr, 32'h100);
    chk("c1_m_width", 32'(m_width), 2);
    chk("c1_stall", 32'(core_stall), 0);
    tick; c_req = 0; #1;
    chk("c1_rvalid", 32'(c_rvalid), 1);
    chk("c1_rdata", c_rdata, 32'hDEADBEEF);
    chk("c1_l_rvalid", 32'(l_rvalid), 0);
    tick;

    // contention: core wins 4 cycles, loader force-granted in the 5th
    c_req = 1; c_we = 0; c_addr = 32'h0;
    l_req = 1; l_we = 0; l_addr = 32'h4; l_width = 2'd2;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("ct_c_gnt", 32'(c_gnt), 1);
      chk("ct_l_gnt", 32'(l_gnt), 0);
      tick;
      chk("ct_cnt", cnt(), 32'(i));
    end
    #1;
    chk("ct_force_l_gnt", 32'(l_gnt), 1);
    chk("ct_force_c_gnt", 32'(c_gnt), 0);
    chk("ct_force_stall", 32'(core_stall), 1);
    chk("ct_force_addr", m_addr, 32'h4);
    tick;
    chk("ct_cnt_clr", cnt(), 0);
    chk("ct_l_rvalid", 32'(l_rvalid), 1);
    chk("ct_l_rdata", l_rdata, 32'h0BADF00D);
    #1;
    chk("ct_c_regain", 32'(c_gnt), 1);
    c_req = 0; l_req = 0;
    tick; tick;

    // alternating owners: core 0x10 then loader 0x20
    c_req = 1; c_we = 0; c_addr = 32'h10;
    #1 chk("alt_c_gnt", 32'(c_gnt), 1);
    tick;
    c_req = 0; l_req = 1; l_we = 0; l_addr = 32'h20;
    #1;
    chk("alt_l_gnt", 32'(l_gnt), 1);
    chk("alt_c_rvalid", 32'(c_rvalid), 1);
    chk("alt_c_rdata", c_rdata, 32'hA5A51010);
    chk("alt_l_rv_early", 32'(l_rvalid), 0);
    tick; l_req = 0; #1;
    chk("alt_l_rvalid", 32'(l_rvalid), 1);
    chk("alt_l_rdata", l_rdata, 32'h5A5A2020);
    chk("alt_c_rv_late", 32'(c_rvalid), 0);
    chk("alt_c_rdata0", c_rdata, 0);
    tick;

    // loader store then load
    l_req = 1; l_we = 1; l_addr = 32'h40; l_wdata = 32'h12345678;
    #1;
    chk("st_m_we", 32'(m_we), 1);
    chk("st_m_wdata", m_wdata, 32'h12345678);
    tick;
    l_we = 0; l_wdata = 0;
    #1;
    chk("st_no_rvalid", 32'({c_rvalid, l_rvalid}), 0);
    chk("ld_l_gnt", 32'(l_gnt), 1);
    tick; l_req = 0; #1;
    chk("ld_l_rvalid", 32'(l_rvalid), 1);
    chk("ld_l_rdata", l_rdata, 32'h12345678);
    tick;

    // reset with a core load presented: nothing issued, no rvalid
    rstd = 1; c_req = 1; c_we = 0; c_addr = 32'h100;
    #1;
    chk("rr_no_gnt", 32'(c_gnt), 0);
    chk("rr_m_en", 32'(m_en), 0);
    tick;
    rstd = 0;
    #1;
    chk("rr_c_rvalid", 32'(c_rvalid), 0);
    chk("rr_cnt", cnt(), 0);
    chk("rr_post_gnt", 32'(c_gnt), 1);
    tick; c_req = 0; #1;
    chk("rr_post_rvalid", 32'(c_rvalid), 1);
    chk("rr_post_rdata", c_rdata, 32'hDEADBEEF);
    tick;

    // idle
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_m_en", 32'(m_en), 0);
      chk("idle_m_bus", m_addr | m_wdata | 32'({m_we, m_width}), 0);
      chk("idle_cnt", cnt(), 0);
      chk("idle_rvalid", 32'({c_rvalid, l_rvalid}), 0);
      tick;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (mem_ctl) between two requesters: the pipeline memory-access stage (port C, core) and the program loader/debug port (port L).
- Issues at most one access per cycle to the memory side. Read data returns one cycle after issue and is routed back to the requester that issued it.
- Core has priority. A starvation counter guarantees the loader forward progress.
- Drives core_stall so the pipeline holds the memory-access stage while the core is not granted.

Parameters:
- STARVE_LIMIT, 4: number of consecutive cycles a pending loader request may be denied before it is force-granted.
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rstd  in  1  synchronous reset, active-high: rstd=1 sampled at a rising edge resets the block.
- c_req  in  1  core access request, level, held until granted.
- c_we  in  1  core store (1) / load (0).
- c_addr  in  32  core byte address.
- c_wdata  in  32  core store data.
- c_width  in  2  core access width code (same encoding as mem_access_width).
- c_gnt  out  1  core request accepted this cycle (combinational).
- c_rvalid  out  1  core load data valid (registered).
- c_rdata  out  32  core load data.
- core_stall  out  1  c_req & ~c_gnt.
- l_req, l_we, l_addr, l_wdata, l_width  in  1/1/32/32/2  loader request bundle, same semantics as core.
- l_gnt  out  1  loader request accepted this cycle.
- l_rvalid  out  1  loader load data valid.
- l_rdata  out  32  loader load data.
- m_en  out  1  memory access strobe.
- m_we  out  1  memory write enable.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_width  out  2  memory width code.
- m_rdata  in  32  memory read data, valid the cycle after a read issue.

Behaviour:
- Grant (combinational from current inputs and registered state):
  - force = l_req & (starve_cnt == STARVE_LIMIT).
  - l_gnt = l_req & (~c_req | force).
  - c_gnt = c_req & ~l_gnt.
  - At most one grant is high per cycle. No grant is issued while rstd=1.
- Memory side:
  - m_en = c_gnt | l_gnt.
  - m_we, m_addr, m_wdata and m_width are muxed from the granted port.
  - With no grant: all memory-side outputs are 0.
- Starvation counter (starve_cnt, CNT_W bits):
  - Reset value 0.
  - Increments when l_req & ~l_gnt, saturating at STARVE_LIMIT.
  - Cleared to 0 when l_gnt=1 or l_req=0.
- Read return (registered):
  - On a rising edge where a granted access is a load (m_en & ~m_we), rd_pend is set to 1 and rd_owner is set to 0 for core, 1 for loader.
  - Otherwise rd_pend is set to 0.
  - c_rvalid = rd_pend & ~rd_owner. l_rvalid = rd_pend & rd_owner.
  - c_rdata and l_rdata both equal m_rdata while their rvalid is high; otherwise 0.
  - Back-to-back loads from alternating owners each receive exactly one rvalid pulse, in issue order, one cycle after their grant.
- Stores: complete at issue. No rvalid pulse is generated.
- Reset:
  - rstd=1 at a rising edge clears starve_cnt, rd_pend and rd_owner.
  - All outputs are 0 during the following cycle, apart from outputs driven by inputs once rstd is deasserted.
  - A load granted in the same cycle that rstd is sampled high produces no rvalid.
- Requests must stay stable while pending; behaviour for a request withdrawn before grant is defined only as "no access issued".
- No combinational path from m_rdata to any grant signal.

Test Plan:
- Core only: c_req=1, c_we=0, c_addr=0x100, width=word, for 1 cycle -> c_gnt=1, m_en=1, m_addr=0x100. Next cycle c_rvalid=1 and c_rdata=m_rdata (0xDEADBEEF); l_rvalid=0.
- Contention: c_req and l_req both held high, STARVE_LIMIT=4 -> c_gnt for 4 cycles while starve_cnt counts 1..4. In cycle 5, l_gnt=1, c_gnt=0 and core_stall=1. Next cycle starve_cnt=0 and the core is granted again.
- Alternating loads: cycle0 core load 0x10, cycle1 loader load 0x20 -> c_rvalid in cycle1 with data for 0x10; l_rvalid in cycle2 with data for 0x20; never both high together.
- Store then load: loader store 0x40 with 0x12345678, then loader load 0x40 -> m_we=1 on the store cycle with no rvalid. The load returns 0x12345678 (memory model) with l_rvalid one cycle after its grant.
- Reset mid-operation: issue core load, assert rstd=1 the next rising edge -> c_rvalid stays 0, starve_cnt=0, and the first post-reset grant proceeds normally.
- Idle: no requests for 10 cycles -> m_en=0, memory-side outputs 0, starve_cnt stays 0, no rvalid pulses.
